// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - run/pause/clear sequencing and mm:ss timekeeping for the stopwatch
// Buttons are synchronised and edge-detected; a prescaler derives the 1 s tick in RUN.
module stopwatch_controller #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int MAX_MINUTES   = 59
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop_btn,
  input  logic       clear_btn,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       overflow,
  output logic       sec_tick
);

  localparam int            PW         = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [5:0]    MAX_MIN    = 6'(MAX_MINUTES);
  localparam logic [5:0]    LAST_SEC   = 6'd59;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          tick_q, tick_d;
  logic          running_q, running_d;
  logic          overflow_q, overflow_d;

  logic ss_s1_q, ss_s2_q, ss_prev_q;
  logic cl_s1_q, cl_s2_q, cl_prev_q;
  logic start_ev, clear_ev;

  assign start_ev = ss_s2_q & ~ss_prev_q;
  assign clear_ev = cl_s2_q & ~cl_prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ss_s1_q    <= 1'b0;
      ss_s2_q    <= 1'b0;
      ss_prev_q  <= 1'b0;
      cl_s1_q    <= 1'b0;
      cl_s2_q    <= 1'b0;
      cl_prev_q  <= 1'b0;
      state_q    <= IDLE;
      presc_q    <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ss_s1_q    <= start_stop_btn;
      ss_s2_q    <= ss_s1_q;
      ss_prev_q  <= ss_s2_q;
      cl_s1_q    <= clear_btn;
      cl_s2_q    <= cl_s1_q;
      cl_prev_q  <= cl_s2_q;
      state_q    <= state_d;
      presc_q    <= presc_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      tick_q     <= tick_d;
      running_q  <= running_d;
      overflow_q <= overflow_d;
    end
  end

  // Clear overrides everything; in RUN the tick is applied before a same-edge pause.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;
    if (clear_ev) begin
      state_d = IDLE;
      presc_d = '0;
      min_d   = '0;
      sec_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d = '0;
          if (start_ev) state_d = RUN;
        end
        RUN: begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (sec_q < LAST_SEC) begin
              sec_d = sec_q + 6'd1;
            end else if (min_q < MAX_MIN) begin
              sec_d = '0;
              min_d = min_q + 6'd1;
            end else begin
              state_d = DONE;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
          if (start_ev && state_d == RUN) state_d = PAUSE;
        end
        PAUSE: begin
          if (start_ev) state_d = RUN;
        end
        DONE: begin
          presc_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    running_d  = (state_d == RUN);
    overflow_d = (state_d == DONE);
  end

  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign running  = running_q;
  assign overflow = overflow_q;
  assign sec_tick = tick_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// tb/tb_stopwatch_controller.sv - self-checking bench for stopwatch_controller
// Directed scenarios plus a randomized run checked against an elapsed-seconds model.
module tb_stopwatch_controller;

  localparam int T    = 4;
  localparam int MAXM = 1;
  localparam int CAP  = MAXM * 60 + 59;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_stop_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic [5:0] minutes, seconds;
  logic       running, overflow, sec_tick;

  int checks = 0;
  int errors = 0;

  stopwatch_controller #(.TICKS_PER_SEC(T), .MAX_MINUTES(MAXM)) dut (
    .clock(clock), .reset(reset), .start_stop_btn(start_stop_btn), .clear_btn(clear_btn),
    .minutes(minutes), .seconds(seconds), .running(running), .overflow(overflow), .sec_tick(sec_tick)
  );

  always #5 clock = ~clock;

  // Reference: total elapsed seconds plus RUN cycles into the current second.
  int         m_total, m_frac, m_mode;
  bit         m_tick;
  logic [2:0] ss_h, cl_h;

  always @(posedge clock or posedge reset) begin : ref_model
    int tot, frac, mode;
    bit tk, st, cl;
    if (reset) begin
      m_total <= 0; m_frac <= 0; m_mode <= M_IDLE; m_tick <= 1'b0;
      ss_h <= 3'b000; cl_h <= 3'b000;
    end else begin
      tot = m_total; frac = m_frac; mode = m_mode; tk = 1'b0;
      st = ss_h[1] & ~ss_h[2];
      cl = cl_h[1] & ~cl_h[2];
      if (cl) begin
        mode = M_IDLE; tot = 0; frac = 0;
      end else if (mode == M_IDLE) begin
        frac = 0;
        if (st) mode = M_RUN;
      end else if (mode == M_RUN) begin
        frac = frac + 1;
        if (frac == T) begin
          frac = 0; tk = 1'b1;
          if (tot == CAP) mode = M_DONE;
          else tot = tot + 1;
        end
        if (st && mode == M_RUN) mode = M_PAUSE;
      end else if (mode == M_PAUSE) begin
        if (st) mode = M_RUN;
      end else begin
        frac = 0;
      end
      m_total <= tot; m_frac <= frac; m_mode <= mode; m_tick <= tk;
      ss_h <= {ss_h[1:0], start_stop_btn};
      cl_h <= {cl_h[1:0], clear_btn};
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; start_stop_btn = 1'b0; clear_btn = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    checks++; if (minutes !== 6'd0) begin errors++; $display("FAIL reset_minutes: got %0d expected 0", minutes); end
    checks++; if (seconds !== 6'd0) begin errors++; $display("FAIL reset_seconds: got %0d expected 0", seconds); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (sec_tick !== 1'b0) begin errors++; $display("FAIL reset_sec_tick: got %b expected 0", sec_tick); end
    cyc(1);
    start_stop_btn = 1'b1; cyc(1); start_stop_btn = 1'b0;
    cyc(12);
    checks++; if (seconds !== 6'd2 || running !== 1'b1) begin errors++; $display("FAIL reset_prerun: got sec=%0d run=%b expected sec=2 run=1", seconds, running); end
    reset = 1'b1;
    #1;
    checks++; if (minutes !== 6'd0 || seconds !== 6'd0 || running !== 1'b0 || overflow !== 1'b0 || sec_tick !== 1'b0)
      begin errors++; $display("FAIL reset_async: got %0d:%0d run=%b ovf=%b tick=%b expected all zero", minutes, seconds, running, overflow, sec_tick); end
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_run_and_hold();
    int ticks;
    do_reset();
    ticks = 0;
    start_stop_btn = 1'b1;
    for (int i = 0; i < 247; i++) begin
      @(negedge clock);
      if (i == 49) start_stop_btn = 1'b0;
      if (sec_tick === 1'b1) ticks++;
      if (i == 2) begin
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_start_latency: got running=%b expected 1", running); end
      end
    end
    checks++; if (minutes !== 6'd1 || seconds !== 6'd1) begin errors++; $display("FAIL run_0101: got %0d:%0d expected 1:1", minutes, seconds); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_held_single_toggle: got running=%b expected 1", running); end
    checks++; if (ticks != 61) begin errors++; $display("FAIL run_tick_count: got %0d expected 61", ticks); end
  endtask

  task automatic test_pause_resume();
    do_reset();
    start_stop_btn = 1'b1; cyc(1); start_stop_btn = 1'b0; cyc(1);
    start_stop_btn = 1'b1; cyc(1); start_stop_btn = 1'b0;
    cyc(2);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_entered: got running=%b expected 0", running); end
    cyc(100);
    checks++; if (minutes !== 6'd0 || seconds !== 6'd0 || running !== 1'b0)
      begin errors++; $display("FAIL pause_frozen: got %0d:%0d run=%b expected 0:0 run=0", minutes, seconds, running); end
    start_stop_btn = 1'b1; cyc(1); start_stop_btn = 1'b0; cyc(2);
    checks++; if (running !== 1'b1 || seconds !== 6'd0) begin errors++; $display("FAIL resume_state: got run=%b sec=%0d expected run=1 sec=0", running, seconds); end
    cyc(1);
    checks++; if (seconds !== 6'd0) begin errors++; $display("FAIL resume_early: got sec=%0d expected 0", seconds); end
    cyc(1);
    checks++; if (seconds !== 6'd1 || sec_tick !== 1'b1) begin errors++; $display("FAIL resume_partial: got sec=%0d tick=%b expected sec=1 tick=1", seconds, sec_tick); end
  endtask

  task automatic test_overflow();
    int bad;
    do_reset();
    start_stop_btn = 1'b1; cyc(1); start_stop_btn = 1'b0;
    cyc(478);
    checks++; if (minutes !== 6'd1 || seconds !== 6'd59 || running !== 1'b1 || overflow !== 1'b0)
      begin errors++; $display("FAIL ovf_at_max: got %0d:%0d run=%b ovf=%b expected 1:59 run=1 ovf=0", minutes, seconds, running, overflow); end
    cyc(4);
    checks++; if (minutes !== 6'd1 || seconds !== 6'd59 || running !== 1'b0 || overflow !== 1'b1)
      begin errors++; $display("FAIL ovf_enter: got %0d:%0d run=%b ovf=%b expected 1:59 run=0 ovf=1", minutes, seconds, running, overflow); end
    bad = 0;
    repeat (200) begin
      cyc(1);
      if (minutes !== 6'd1 || seconds !== 6'd59 || overflow !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ovf_hold: got %0d bad cycles expected 0", bad); end
    start_stop_btn = 1'b1; cyc(1); start_stop_btn = 1'b0; cyc(5);
    checks++; if (overflow !== 1'b1 || running !== 1'b0 || seconds !== 6'd59)
      begin errors++; $display("FAIL ovf_start_ignored: got ovf=%b run=%b sec=%0d expected ovf=1 run=0 sec=59", overflow, running, seconds); end
    clear_btn = 1'b1; cyc(1); clear_btn = 1'b0; cyc(2);
    checks++; if (minutes !== 6'd0 || seconds !== 6'd0 || overflow !== 1'b0 || running !== 1'b0)
      begin errors++; $display("FAIL ovf_clear: got %0d:%0d ovf=%b run=%b expected 0:0 ovf=0 run=0", minutes, seconds, overflow, running); end
  endtask

  task automatic test_clear_and_start();
    do_reset();
    start_stop_btn = 1'b1; cyc(1); start_stop_btn = 1'b0;
    cyc(29);
    start_stop_btn = 1'b1; clear_btn = 1'b1; cyc(1);
    start_stop_btn = 1'b0; clear_btn = 1'b0; cyc(1);
    checks++; if (seconds !== 6'd7 || running !== 1'b1) begin errors++; $display("FAIL both_pre: got sec=%0d run=%b expected sec=7 run=1", seconds, running); end
    cyc(1);
    checks++; if (minutes !== 6'd0 || seconds !== 6'd0 || running !== 1'b0)
      begin errors++; $display("FAIL both_clear_wins: got %0d:%0d run=%b expected 0:0 run=0", minutes, seconds, running); end
    cyc(2);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL both_start_discarded: got run=%b expected 0", running); end
    start_stop_btn = 1'b1; cyc(1); start_stop_btn = 1'b0; cyc(2);
    checks++; if (running !== 1'b1 || seconds !== 6'd0) begin errors++; $display("FAIL both_restart: got run=%b sec=%0d expected run=1 sec=0", running, seconds); end
    cyc(4);
    checks++; if (seconds !== 6'd1) begin errors++; $display("FAIL both_restart_tick: got sec=%0d expected 1", seconds); end
  endtask

  task automatic test_start_on_tick();
    do_reset();
    start_stop_btn = 1'b1; cyc(1); start_stop_btn = 1'b0;
    cyc(15);
    checks++; if (seconds !== 6'd3) begin errors++; $display("FAIL tick_pause_pre: got sec=%0d expected 3", seconds); end
    start_stop_btn = 1'b1; cyc(1); start_stop_btn = 1'b0; cyc(2);
    checks++; if (seconds !== 6'd4 || sec_tick !== 1'b1 || running !== 1'b0)
      begin errors++; $display("FAIL tick_pause_edge: got sec=%0d tick=%b run=%b expected sec=4 tick=1 run=0", seconds, sec_tick, running); end
    cyc(8);
    checks++; if (seconds !== 6'd4 || running !== 1'b0) begin errors++; $display("FAIL tick_pause_hold: got sec=%0d run=%b expected sec=4 run=0", seconds, running); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      checks++; if (minutes !== 6'(m_total / 60)) begin errors++; $display("FAIL rand_minutes cyc %0d: got %0d expected %0d", i, minutes, m_total / 60); end
      checks++; if (seconds !== 6'(m_total % 60)) begin errors++; $display("FAIL rand_seconds cyc %0d: got %0d expected %0d", i, seconds, m_total % 60); end
      checks++; if (running !== (m_mode == M_RUN)) begin errors++; $display("FAIL rand_running cyc %0d: got %b expected %b", i, running, m_mode == M_RUN); end
      checks++; if (overflow !== (m_mode == M_DONE)) begin errors++; $display("FAIL rand_overflow cyc %0d: got %b expected %b", i, overflow, m_mode == M_DONE); end
      checks++; if (sec_tick !== m_tick) begin errors++; $display("FAIL rand_sec_tick cyc %0d: got %b expected %b", i, sec_tick, m_tick); end
      if ($urandom_range(0, 11) == 0) start_stop_btn = ~start_stop_btn;
      if ($urandom_range(0, 96) == 0) clear_btn = ~clear_btn;
      cyc(1);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_run_and_hold();
    test_pause_resume();
    test_overflow();
    test_clear_and_start();
    test_start_on_tick();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
- Sequences the stopwatch datapath.
- Turns raw start/stop and clear buttons into run/pause/clear control.
- Divides the system clock down to a 1-second tick.
- Keeps the binary minutes/seconds count that feeds seven_segment_driver's minutes[5:0] and seconds[5:0] inputs.
- Sits between the board buttons and the display driver. It is the only block that owns elapsed time.

Parameters:
- TICKS_PER_SEC, 50000000: clock cycles per second. Legal range ≥ 2; benches use 4.
- MAX_MINUTES, 59: highest minutes value reached before saturation. Legal range 1..63.

Ports:
- clock  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- start_stop_btn  input  1  raw, asynchronous button level. A rising edge toggles run/pause.
- clear_btn  input  1  raw, asynchronous button level. A rising edge clears to 00:00.
- minutes  output  6  elapsed minutes, binary, 0..MAX_MINUTES.
- seconds  output  6  elapsed seconds, binary, 0..59.
- running  output  1  high while in RUN.
- overflow  output  1  high while in DONE.
- sec_tick  output  1  one-cycle pulse on the edge where seconds advances.

Behaviour:

Reset and timing:
- Reset is asynchronous and active-high, and wins over everything. On reset: state=IDLE; minutes=0, seconds=0, running=0, overflow=0, sec_tick=0; prescaler=0; all synchronizer and edge flops=0.
- Asserting reset mid-run zeroes the outputs immediately, without waiting for a clock edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Button conditioning, per button:
- Two-flop synchronizer (s1, s2), then a previous-value flop.
- Press event = s2 & ~prev.
- If the input is first sampled high on edge k, the event is high in the cycle after edge k+1, and the state change lands on edge k+2.
- A held button produces exactly one event. Bounce filtering is not in scope; it is handled upstream.

State machine (IDLE, RUN, PAUSE, DONE):
- IDLE: start event -> RUN.
- RUN: start event -> PAUSE. A second tick while at MAX_MINUTES:59 -> DONE.
- PAUSE: start event -> RUN.
- DONE: start events are ignored.
- Any state: clear event -> IDLE. Clear sets minutes=0, seconds=0, prescaler=0, sec_tick=0.
- Clear and start events in the same cycle: clear wins, state=IDLE, and the start event is discarded.
- running is registered and equals (next state == RUN). overflow likewise equals (next state == DONE).

Prescaler:
- Width $clog2(TICKS_PER_SEC).
- Counts only in RUN.
- Holds its value in PAUSE, so the partial second is preserved across a pause.
- Held at 0 in IDLE and DONE.
- Wraps at TICKS_PER_SEC-1 -> 0. That edge is the second tick.

Second tick, which occurs only in RUN:
- sec_tick=1 for exactly one cycle, together with the count update.
- If seconds < 59: seconds+1.
- If seconds == 59 and minutes < MAX_MINUTES: seconds=0, minutes+1.
- If seconds == 59 and minutes == MAX_MINUTES: counts hold at MAX_MINUTES:59, state -> DONE, overflow=1, running=0.
- A start event on the same edge as a tick: the tick is applied first, then state -> PAUSE. The count still advances.
- A clear event on the same edge as a tick: clear wins, count=00:00, sec_tick=0.

Timing figures:
- First increment occurs TICKS_PER_SEC RUN cycles after entering RUN from IDLE.
- Resuming from PAUSE with prescaler p gives the next increment after TICKS_PER_SEC-p RUN cycles.
- Outputs never exceed 59 seconds or MAX_MINUTES minutes.

Test Plan (TICKS_PER_SEC=4 unless noted):
1. Assert reset for 3 cycles, release -> minutes=0, seconds=0, running=0, overflow=0, sec_tick=0. Re-assert reset mid-RUN between clock edges -> outputs zero before the next edge.
2. One start press, then run 61*4 cycles past the state change -> 01:01, running=1, exactly 61 sec_tick pulses. Holding the button for 50 cycles -> only one toggle.
3. Start; pause when prescaler=2; idle 100 cycles (count frozen at 00:00, running=0); start again -> seconds becomes 1 after exactly 2 RUN cycles.
4. MAX_MINUTES=1: run to 01:59, then one more tick -> overflow=1, running=0, display held at 01:59 for 200 cycles. Start press ignored. Clear press -> 00:00, overflow=0.
5. Press start and clear in the same cycle during RUN at 00:07 -> IDLE, 00:00, running=0. Start alone afterwards -> RUN from 00:00.
6. Start press timed so its event coincides with a tick at 00:03 -> 00:04, sec_tick=1, then PAUSE with running=0.
